// File: rtl/pcm_stream_decoder_if.sv
// Stream bundle between the bit synchroniser and the PCM decoder:
// symbol strobe/data in, decoded bit strobe/data and window statistics out.
interface pcm_stream_decoder_if #(
    parameter int WIN_W = 16
);
    logic             symClkEn;
    logic             symBit;
    logic             bitOut;
    logic             bitEnOut;
    logic             windowDone;
    logic [WIN_W-1:0] violationCount;

    modport master (
        output symClkEn, symBit,
        input  bitOut, bitEnOut, windowDone, violationCount
    );

    modport slave (
        input  symClkEn, symBit,
        output bitOut, bitEnOut, windowDone, violationCount
    );
endinterface

// File: rtl/pcm_stream_decoder.sv
// PCM symbol-stream decoder: NRZ-L/M/S decode, programmable self-synchronising
// derandomizer, output inversion, and a windowed run-length monitor.
// Fixed two-cycle latency from symClkEn to bitEnOut.
module pcm_stream_decoder #(
    parameter int LFSR_MAX  = 23,
    parameter int RUN_CNT_W = 8,
    parameter int WIN_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           nrzMode,
    input  logic [LFSR_MAX-1:0]  derandTaps,
    input  logic                 dataInvert,
    input  logic [RUN_CNT_W-1:0] runLimit,
    input  logic [WIN_W-1:0]     windowLen,
    input  logic                 clearStats,
    pcm_stream_decoder_if.slave  bus
);

    logic                 last_sym;
    logic                 dec;
    logic                 dec_next;
    logic                 v1;
    logic [LFSR_MAX-1:0]  sr;
    logic                 fb;

    logic                 prev_bit;
    logic [RUN_CNT_W-1:0] run_cnt;
    logic [RUN_CNT_W-1:0] run_next;
    logic [WIN_W-1:0]     win_cnt;
    logic [WIN_W-1:0]     win_next;
    logic [WIN_W-1:0]     viol_acc;
    logic [WIN_W-1:0]     acc_next;
    logic                 same_bit;
    logic                 run_sat;
    logic                 viol_hit;
    logic                 win_close;

    // Mark/space decode of the incoming symbol against the previous symbol
    always_comb begin
        dec_next = bus.symBit;
        case (nrzMode)
            2'd1:    dec_next = bus.symBit ^ last_sym;
            2'd2:    dec_next = ~(bus.symBit ^ last_sym);
            default: dec_next = bus.symBit;
        endcase
    end

    // Stage 1: capture the decoded bit and remember the raw symbol for the next decode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_sym <= 1'b0;
            dec      <= 1'b0;
            v1       <= 1'b0;
        end else begin
            v1 <= bus.symClkEn;
            if (bus.symClkEn) begin
                last_sym <= bus.symBit;
                dec      <= dec_next;
            end
        end
    end

    // Feedback uses the history of decoded (still scrambled) bits, so no seed is needed
    assign fb = ^(sr & derandTaps);

    // Stage 2: derandomize, invert and present the output strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr           <= '0;
            bus.bitOut   <= 1'b0;
            bus.bitEnOut <= 1'b0;
        end else begin
            bus.bitEnOut <= v1;
            if (v1) begin
                sr         <= {sr[LFSR_MAX-2:0], dec};
                bus.bitOut <= dec ^ fb ^ dataInvert;
            end
        end
    end

    // Next values for the run and window counters for the bit currently presented.
    // A saturated run continuing is not a new arrival at runLimit, so it never re-counts.
    always_comb begin
        same_bit = (bus.bitOut == prev_bit);
        run_sat  = &run_cnt;
        if (!same_bit) begin
            run_next = RUN_CNT_W'(1);
        end else if (run_sat) begin
            run_next = run_cnt;
        end else begin
            run_next = run_cnt + 1'b1;
        end
        viol_hit  = (runLimit != '0) && (run_next == runLimit) && !(same_bit && run_sat);
        acc_next  = (viol_hit && !(&viol_acc)) ? viol_acc + 1'b1 : viol_acc;
        win_next  = win_cnt + 1'b1;
        win_close = (windowLen != '0) && (win_next == windowLen);
    end

    // Run-length monitor and statistics window; clearStats wins over a coincident bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_bit           <= 1'b0;
            run_cnt            <= '0;
            win_cnt            <= '0;
            viol_acc           <= '0;
            bus.violationCount <= '0;
            bus.windowDone     <= 1'b0;
        end else begin
            bus.windowDone <= 1'b0;
            if (bus.bitEnOut) begin
                prev_bit <= bus.bitOut;
            end
            if (clearStats) begin
                run_cnt            <= '0;
                win_cnt            <= '0;
                viol_acc           <= '0;
                bus.violationCount <= '0;
            end else if (bus.bitEnOut) begin
                run_cnt <= run_next;
                if (win_close) begin
                    bus.violationCount <= acc_next;
                    viol_acc           <= '0;
                    win_cnt            <= '0;
                    bus.windowDone     <= 1'b1;
                end else begin
                    viol_acc <= acc_next;
                    if (windowLen != '0) begin
                        win_cnt <= win_next;
                    end
                end
            end
        end
    end

endmodule

// File: doc/pcm_stream_decoder.md
# pcm_stream_decoder

Parametrised PCM symbol-stream decoder. Successor to the fixed single-mode decoder: it adds a programmable-polynomial derandomizer of any length up to `LFSR_MAX`, a two-stage fixed-latency pipeline, and a windowed run-length (transition-density) monitor that software uses to judge derandomizer/bit-sync health. It sits between the bit synchroniser (symbol enables) and the PCM encoder/output formatter, one instance per data channel.

## Interface
- `LFSR_MAX`, 23: maximum derandomizer register length; width of `derandTaps`.
- `RUN_CNT_W`, 8: width of the run-length counter and `runLimit`.
- `WIN_W`, 16: width of the window counter, `windowLen` and `violationCount`.

- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `symClkEn`  in  1  one-cycle strobe; `symBit` is valid this cycle. Back-to-back strobes are legal.
- `symBit`  in  1  received symbol.
- `nrzMode`  in  2  0 = NRZ-L, 1 = NRZ-M, 2 = NRZ-S, 3 = NRZ-L.
- `derandTaps`  in  LFSR_MAX  feedback mask. Bit k selects the decoded bit delayed k+1 symbols. An all-zero mask gives pass-through.
- `dataInvert`  in  1  inverts the output bit.
- `runLimit`  in  RUN_CNT_W  run length that counts as a violation. 0 disables the monitor.
- `windowLen`  in  WIN_W  output bits per statistics window. 0 means free-running: no window ends.
- `clearStats`  in  1  synchronous clear of the run, window and violation counters.
- `bitOut`  out  1  decoded bit.
- `bitEnOut`  out  1  one-cycle strobe; `bitOut` is valid this cycle.
- `windowDone`  out  1  one-cycle pulse at the end of each window.
- `violationCount`  out  WIN_W  violations counted in the last completed window. Holds until the next window end.

## Operation
- Stage 1 (mark/space decode):
  - On `symClkEn`, register `dec` and `lastSym <= symBit`.
  - `dec` is `symBit` for NRZ-L, `symBit^lastSym` for NRZ-M, and `~(symBit^lastSym)` for NRZ-S.
  - `v1` is a one-cycle valid flag.
- Stage 2 (derandomize, invert), active when `v1`:
  - `sr <= {sr[LFSR_MAX-2:0], dec}`.
  - `fb = ^(sr & derandTaps)`, evaluated on `sr` before the shift.
  - `bitOut <= dec ^ fb ^ dataInvert`.
  - `bitEnOut <= 1`. It is 0 in every other cycle.
- Standard polynomial settings:
  - RNRZ15: taps `0x006000`
  - RNRZ9: `0x000110`
  - RNRZ11: `0x000500`
  - RNRZ17: `0x012000`
  - RNRZ23: `0x420000`
- The derandomizer is self-synchronising. No seed is needed; output is correct after L input bits, where L is the highest set tap bit + 1.
- Configuration inputs are sampled live. A change takes effect on the next strobe it affects. Nothing is flushed.
- Run monitor, on each `bitEnOut`:
  - If `bitOut` equals the previous output bit, `runCnt` increments, saturating at all-ones. Otherwise `runCnt` is set to 1.
  - When `runCnt` becomes exactly `runLimit` (with `runLimit` ≠ 0), `violAcc` increments, saturating at all-ones. This happens once per run, however long the run continues.
- Window, on each `bitEnOut` with `windowLen` ≠ 0:
  - `winCnt` increments.
  - When it reaches `windowLen`: `violationCount <= violAcc` (including any violation from this same bit), `violAcc <= 0`, `winCnt <= 0`, and `windowDone` pulses. `runCnt` is not cleared, so runs carry across windows.
- `clearStats` zeroes `runCnt`, `winCnt`, `violAcc` and `violationCount`, and suppresses `windowDone`. It has priority over a simultaneous `bitEnOut` in the counters only; the data path still advances.

## Timing
- Reset values: all outputs and all state are 0. This covers `lastSym`, `sr`, `v1`, the counters and the previous-bit register.
- Latency: `symClkEn` in cycle t gives `bitEnOut` in cycle t+2. Exactly one output strobe per input strobe, with no gaps or merging, including strobes every cycle.
- `windowDone` and the `violationCount` update occur in cycle t+3, one cycle after the closing `bitEnOut`.
- Reset asserted mid-stream: state clears asynchronously and any in-flight strobe is lost. The first strobe after release is decoded against `lastSym` = 0.
- Setting `windowLen` below the current `winCnt` closes the window when `winCnt` wraps past all-ones and reaches the new value. Software must issue `clearStats` after changing `windowLen`.

## Test plan
- NRZ-M, taps 0, symbols 0,1,1,0 on consecutive `symClkEn`: `bitOut` is 0,1,0,1, each at t+2 relative to its input strobe, with `bitEnOut` high every cycle.
- RNRZ15 encoder model feeding all-zeros data through NRZ-L with taps `0x006000`: after 15 bits, `bitOut` is constant 0 for 32767 bits. With `dataInvert` = 1, it is constant 1.
- `runLimit` = 4, `windowLen` = 16, output pattern 00000 1 0000 111111: `violationCount` = 3 at `windowDone`, one cycle after the 16th `bitEnOut`.
- 70000 identical bits with `runLimit` = 2 and `windowLen` = 0: `runCnt` saturates at 255, `violAcc` = 1, and `windowDone` never pulses.
- `clearStats` in the same cycle as the window-closing `bitEnOut`: no `windowDone`, `violationCount` = 0, and `bitOut` is still correct.
- `reset_n` pulsed low between two strobes: every output reads 0 immediately. The next strobe in NRZ-S with `symBit` = 0 gives `bitOut` = 1.
